sram_2rw_param: RTL and testbench

//  Parametrised two-port read/write SRAM behavioural macro model. Successor to the fixed 16x32 2RW model.
//  - Single clock, asynchronous active-low reset.
//  - Per-byte write masks and read-valid strobes.
//  - Defined same-address collision policy.
//  - Power-on clear sequencer that zeroes the array before ports are accepted.

---
 rtl/sram_2rw_pkg.sv | 8 +
 rtl/sram_2rw_if.sv | 17 +
 rtl/sram_2rw_clear_fsm.sv | 41 ++++
 rtl/sram_2rw_param.sv | 100 ++++++++++
 tb/tb_sram_2rw_param.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_2rw_pkg.sv
// sram_2rw_pkg: shared types, constants and byte-merge helper for the 2RW SRAM model.
package sram_2rw_pkg;
    typedef enum logic [1:0] {CLEAR, DONE, RUN} clr_state_t;
    localparam int BYTE_W = 8;
    function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old, data, input logic mask_n);
        return mask_n ? old : data;
    endfunction
endpackage

// File: rtl/sram_2rw_if.sv
// sram_2rw_if: one SRAM access port (address, active-low controls, byte mask, data, read strobe).
interface sram_2rw_if #(
    parameter int AW    = 4,
    parameter int WIDTH = 32
);
    localparam int MW = WIDTH / 8;
    logic [AW-1:0]    A;
    logic             CSB;
    logic             WEB;
    logic             OEB;
    logic [MW-1:0]    BMB;
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic             OV;
    modport master(output A, CSB, WEB, OEB, BMB, I, input O, OV);
    modport slave(input A, CSB, WEB, OEB, BMB, I, output O, OV);
endinterface

// File: rtl/sram_2rw_clear_fsm.sv
// sram_2rw_clear_fsm: power-on clear sequencer; zeroes one word per cycle, then raises READY.
module sram_2rw_clear_fsm
    import sram_2rw_pkg::*;
#(
    parameter int   DEPTH = 16,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic          CE,
    input  logic          RSTB,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_DONE  = DONE;
    localparam logic [1:0] S_RUN   = RUN;
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          last;
    always_comb begin
        last    = cnt_q == AW'(DEPTH - 1);
        state_d = state_q == S_CLEAR ? (last ? S_DONE : S_CLEAR) : S_RUN;
        cnt_d   = (state_q == S_CLEAR && !last) ? cnt_q + AW'(1) : cnt_q;
        ready_d = state_q != S_CLEAR;
    end
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end
    assign ready_o    = ready_q;
    assign clr_we_o   = state_q == S_CLEAR;
    assign clr_addr_o = cnt_q;
endmodule

// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised two-port R/W SRAM model with byte masks, read-first collisions and power-on clear.
// Define SRAM_2RW_OUTREG_EN to add an output pipeline register (2-cycle read latency).
module sram_2rw_param
    import sram_2rw_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int MW    = WIDTH / 8
) (
    input  logic      CE,
    input  logic      RSTB,
    output logic      READY,
    output logic      COLL,
    sram_2rw_if.slave p1,
    sram_2rw_if.slave p2
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             in1, in2, rd1, rd2, wr1, wr2, coll_d, coll_q;
    logic [MW-1:0]    en1, en2;
    logic [WIDTH-1:0] o1_q, o2_q;
    logic             ov1_q, ov2_q;

    sram_2rw_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .CE        (CE),
        .RSTB      (RSTB),
        .ready_o   (READY),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign in1    = 32'(p1.A) < 32'(DEPTH);
    assign in2    = 32'(p2.A) < 32'(DEPTH);
    assign rd1    = READY & ~p1.CSB & ~p1.OEB;
    assign rd2    = READY & ~p2.CSB & ~p2.OEB;
    assign wr1    = READY & ~p1.CSB & ~p1.WEB & in1;
    assign wr2    = READY & ~p2.CSB & ~p2.WEB & in2;
    assign en1    = wr1 ? ~p1.BMB : '0;
    assign en2    = wr2 ? ~p2.BMB : '0;
    assign coll_d = wr1 & wr2 & (p1.A == p2.A) & |(en1 & en2);

    // Port 2 merged first so port 1 overrides it on shared bytes
    always_ff @(posedge CE) begin
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < MW; k++) begin
                mem_q[w][k*BYTE_W +: BYTE_W] <= (clr_we && clr_addr == AW'(w)) ? '0 :
                    byte_merge(byte_merge(mem_q[w][k*BYTE_W +: BYTE_W], p2.I[k*BYTE_W +: BYTE_W],
                                          !(en2[k] && p2.A == AW'(w))),
                               p1.I[k*BYTE_W +: BYTE_W], !(en1[k] && p1.A == AW'(w)));
            end
        end
    end

    // Reads sample pre-edge contents, giving read-first behaviour
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            o1_q   <= '0;
            o2_q   <= '0;
            ov1_q  <= 1'b0;
            ov2_q  <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            ov1_q  <= rd1;
            ov2_q  <= rd2;
            coll_q <= coll_d;
            if (rd1) o1_q <= in1 ? mem_q[p1.A] : '0;
            if (rd2) o2_q <= in2 ? mem_q[p2.A] : '0;
        end
    end
    assign COLL = coll_q;

`ifdef SRAM_2RW_OUTREG_EN
    logic [WIDTH-1:0] o1r_q, o2r_q;
    logic             ov1r_q, ov2r_q;
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            o1r_q  <= '0;
            o2r_q  <= '0;
            ov1r_q <= 1'b0;
            ov2r_q <= 1'b0;
        end else begin
            o1r_q  <= o1_q;
            o2r_q  <= o2_q;
            ov1r_q <= ov1_q;
            ov2r_q <= ov2_q;
        end
    end
    assign p1.O  = o1r_q;
    assign p2.O  = o2r_q;
    assign p1.OV = ov1r_q;
    assign p2.OV = ov2r_q;
`else
    assign p1.O  = o1_q;
    assign p2.O  = o2_q;
    assign p1.OV = ov1_q;
    assign p2.OV = ov2_q;
`endif
endmodule

// File: tb/tb_sram_2rw_param.sv
// tb_sram_2rw_param: drives a DEPTH=16 and a DEPTH=12 instance with identical stimulus against a behavioural model.
module tb_sram_2rw_param;
    localparam int LAT =
`ifdef SRAM_2RW_OUTREG_EN
        2;
`else
        1;
`endif
    logic CE = 1'b0, RSTB = 1'b1;
    always #5 CE = ~CE;

    sram_2rw_if #(.AW(4), .WIDTH(32)) a1 (), a2 (), b1 (), b2 ();
    logic [1:0] rdy, coll;
    sram_2rw_param #(.DEPTH(16), .WIDTH(32)) u16 (.CE(CE), .RSTB(RSTB), .READY(rdy[0]), .COLL(coll[0]), .p1(a1), .p2(a2));
    sram_2rw_param #(.DEPTH(12), .WIDTH(32)) u12 (.CE(CE), .RSTB(RSTB), .READY(rdy[1]), .COLL(coll[1]), .p1(b1), .p2(b2));

    logic [31:0] act_o [2][2];
    logic        act_ov [2][2];
    always_comb begin
        act_o[0][0] = a1.O; act_o[0][1] = a2.O; act_o[1][0] = b1.O; act_o[1][1] = b2.O;
        act_ov[0][0] = a1.OV; act_ov[0][1] = a2.OV; act_ov[1][0] = b1.OV; act_ov[1][1] = b2.OV;
    end

    int checks = 0, errors = 0;
    logic        c_rd [2], c_wr [2];
    logic [3:0]  c_a [2], c_bm [2];
    logic [31:0] c_d [2];
    logic [31:0] m [2][16];
    logic [31:0] s1o [2][2], eo [2][2];
    logic        s1ov [2][2], eov [2][2];
    logic        ecoll [2], erdy [2];
    int          edges;

    function automatic int dep(int d);
        return d == 0 ? 16 : 12;
    endfunction

    task automatic set_port(int p, logic rd, logic wr, logic [3:0] a, logic [3:0] bm, logic [31:0] d);
        c_rd[p] = rd; c_wr[p] = wr; c_a[p] = a; c_bm[p] = bm; c_d[p] = d;
    endtask

    task automatic idle();
        set_port(0, 0, 0, 0, 4'hF, 0);
        set_port(1, 0, 0, 0, 4'hF, 0);
    endtask

    task automatic drive();
        a1.CSB = !(c_rd[0] || c_wr[0]); a1.OEB = !c_rd[0]; a1.WEB = !c_wr[0];
        a1.A = c_a[0]; a1.BMB = c_bm[0]; a1.I = c_d[0];
        b1.CSB = a1.CSB; b1.OEB = a1.OEB; b1.WEB = a1.WEB; b1.A = c_a[0]; b1.BMB = c_bm[0]; b1.I = c_d[0];
        a2.CSB = !(c_rd[1] || c_wr[1]); a2.OEB = !c_rd[1]; a2.WEB = !c_wr[1];
        a2.A = c_a[1]; a2.BMB = c_bm[1]; a2.I = c_d[1];
        b2.CSB = a2.CSB; b2.OEB = a2.OEB; b2.WEB = a2.WEB; b2.A = c_a[1]; b2.BMB = c_bm[1]; b2.I = c_d[1];
    endtask

    // One clock: drive at the falling edge, predict, return at the next falling edge
    task automatic step();
        logic        rd, ready;
        logic        wr [2];
        logic [31:0] rdata;
        drive();
        for (int d = 0; d < 2; d++) begin
            ready = edges >= dep(d) + 1;
            for (int p = 0; p < 2; p++) begin
                rd    = ready && c_rd[p];
                wr[p] = ready && c_wr[p] && int'(c_a[p]) < dep(d);
                rdata = int'(c_a[p]) < dep(d) ? m[d][c_a[p]] : 32'h0;
                if (LAT == 2) begin eo[d][p] = s1o[d][p]; eov[d][p] = s1ov[d][p]; end
                s1ov[d][p] = rd;
                if (rd) s1o[d][p] = rdata;
                if (LAT == 1) begin eo[d][p] = s1o[d][p]; eov[d][p] = s1ov[d][p]; end
            end
            ecoll[d] = wr[0] && wr[1] && c_a[0] == c_a[1] && (~c_bm[0] & ~c_bm[1]) != 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (wr[1] && !c_bm[1][k] && !(wr[0] && c_a[0] == c_a[1] && !c_bm[0][k]))
                    m[d][c_a[1]][8*k +: 8] = c_d[1][8*k +: 8];
                if (wr[0] && !c_bm[0][k])
                    m[d][c_a[0]][8*k +: 8] = c_d[0][8*k +: 8];
            end
        end
        edges++;
        for (int d = 0; d < 2; d++) erdy[d] = edges >= dep(d) + 1;
        @(posedge CE);
        @(negedge CE);
    endtask

    task automatic settle();
        idle();
        repeat (LAT - 1) step();
    endtask

    task automatic test_reset();
        idle();
        drive();
        RSTB = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || coll[d] !== 1'b0) begin
                errors++; $display("FAIL reset_ctl d%0d ready=%b coll=%b want 0 0", d, rdy[d], coll[d]);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (act_o[d][p] !== 32'h0 || act_ov[d][p] !== 1'b0) begin
                    errors++; $display("FAIL reset_out d%0d p%0d O=%h OV=%b want 0 0", d, p, act_o[d][p], act_ov[d][p]);
                end
                s1o[d][p] = 0; s1ov[d][p] = 0; eo[d][p] = 0; eov[d][p] = 0;
            end
            ecoll[d] = 0; erdy[d] = 0;
            for (int w = 0; w < 16; w++) m[d][w] = 32'h0;
        end
        edges = 0;
        @(negedge CE);
        RSTB = 1'b1;
    endtask

    task automatic test_ready_timing();
        int t [2];
        t[0] = -1; t[1] = -1;
        set_port(0, 1, 1, 0, 4'h0, 32'hFFFF_FFFF);
        set_port(1, 1, 1, 0, 4'h0, 32'h1234_5678);
        for (int s = 1; s <= 40 && t[0] < 0; s++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy[d] !== erdy[d] || coll[d] !== 1'b0 || act_ov[d][0] !== 1'b0 || act_ov[d][1] !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_phase d%0d step %0d ready=%b want %b coll=%b ov=%b%b want 0", d, s, rdy[d], erdy[d],
                             coll[d], act_ov[d][0], act_ov[d][1]);
                end
                if (rdy[d] === 1'b1 && t[d] < 0) t[d] = s;
            end
            if (t[1] >= 0) idle();
        end
        checks++;
        if (t[0] != 17) begin errors++; $display("FAIL ready_rise16 got %0d want 17", t[0]); end
        checks++;
        if (t[1] != 13) begin errors++; $display("FAIL ready_rise12 got %0d want 13", t[1]); end
    endtask

    task automatic test_read_all();
        for (int s = 0; s < 16 + LAT; s++) begin
            idle();
            if (s < 16) begin
                set_port(0, 1, 0, 4'(s), 4'hF, 0);
                set_port(1, 1, 0, 4'(15 - s), 4'hF, 0);
            end
            step();
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (act_o[d][p] !== 32'h0 || act_ov[d][p] !== (s >= LAT - 1 && s < 15 + LAT)) begin
                        errors++;
                        $display("FAIL read_all d%0d p%0d step %0d O=%h OV=%b want 0 %b", d, p, s, act_o[d][p], act_ov[d][p],
                                 s >= LAT - 1 && s < 15 + LAT);
                    end
                end
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] want [2];
        want[0] = 32'h0000_BEEF; want[1] = 32'h1122_BEEF;
        for (int i = 0; i < 2; i++) begin
            idle();
            set_port(0, 0, 1, 3, i == 0 ? 4'b1100 : 4'b0011, i == 0 ? 32'hDEAD_BEEF : 32'h1122_3344);
            step();
            set_port(0, 1, 0, 3, 4'hF, 0);
            step();
            settle();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act_o[d][0] !== want[i] || act_ov[d][0] !== 1'b1) begin
                    errors++; $display("FAIL byte_mask d%0d #%0d O=%h OV=%b want %h 1", d, i, act_o[d][0], act_ov[d][0], want[i]);
                end
            end
        end
    endtask

    task automatic test_read_first();
        idle();
        set_port(0, 0, 1, 5, 4'h0, 32'hAAAA_AAAA);
        set_port(1, 1, 0, 5, 4'hF, 0);
        step();
        settle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_o[d][1] !== 32'h0 || act_ov[d][1] !== 1'b1) begin
                errors++; $display("FAIL rf_cross d%0d O2=%h OV2=%b want 0 1", d, act_o[d][1], act_ov[d][1]);
            end
        end
        set_port(0, 1, 1, 5, 4'h0, 32'h5555_5555);
        set_port(1, 1, 0, 5, 4'hF, 0);
        step();
        settle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_o[d][0] !== 32'hAAAA_AAAA || act_o[d][1] !== 32'hAAAA_AAAA) begin
                errors++; $display("FAIL rf_same d%0d O1=%h O2=%h want aaaaaaaa", d, act_o[d][0], act_o[d][1]);
            end
        end
        set_port(1, 1, 0, 5, 4'hF, 0);
        step();
        settle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (act_o[d][1] !== 32'h5555_5555) begin
                errors++; $display("FAIL rf_after d%0d O2=%h want 55555555", d, act_o[d][1]);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] want [2];
        logic        wcoll [2];
        want[0] = 32'h1111_1111; want[1] = 32'h2222_1111;
        wcoll[0] = 1'b1; wcoll[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle();
            set_port(0, 0, 1, 7, i == 0 ? 4'b0000 : 4'b1100, 32'h1111_1111);
            set_port(1, 0, 1, 7, i == 0 ? 4'b0000 : 4'b0011, 32'h2222_2222);
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (coll[d] !== wcoll[i]) begin
                    errors++; $display("FAIL coll_pulse d%0d #%0d COLL=%b want %b", d, i, coll[d], wcoll[i]);
                end
            end
            idle();
            set_port(0, 1, 0, 7, 4'hF, 0);
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (coll[d] !== 1'b0) begin
                    errors++; $display("FAIL coll_clear d%0d #%0d COLL=%b want 0", d, i, coll[d]);
                end
            end
            settle();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (act_o[d][0] !== want[i]) begin
                    errors++; $display("FAIL coll_data d%0d #%0d O=%h want %h", d, i, act_o[d][0], want[i]);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        idle();
        set_port(0, 0, 1, 13, 4'h0, 32'hCAFE_F00D);
        set_port(1, 0, 1, 13, 4'b1110, 32'h0BAD_BEEF);
        step();
        checks++;
        if (coll[0] !== 1'b1 || coll[1] !== 1'b0) begin
            errors++; $display("FAIL oor_coll COLL16=%b COLL12=%b want 1 0", coll[0], coll[1]);
        end
        idle();
        set_port(0, 1, 0, 13, 4'hF, 0);
        step();
        settle();
        checks++;
        if (act_o[1][0] !== 32'h0 || act_ov[1][0] !== 1'b1) begin
            errors++; $display("FAIL oor_read12 O=%h OV=%b want 0 1", act_o[1][0], act_ov[1][0]);
        end
        checks++;
        if (act_o[0][0] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL oor_read16 O=%h want cafef00d", act_o[0][0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [3:0]  a0;
        for (int n = 0; n < 400; n++) begin
            r  = $urandom;
            a0 = 4'($urandom_range(0, 15));
            set_port(0, r[0], r[1], a0, r[11:8], $urandom);
            set_port(1, r[2], r[3], r[4] ? a0 : 4'($urandom_range(0, 15)), r[15:12], $urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (act_o[d][p] !== eo[d][p] || act_ov[d][p] !== eov[d][p]) begin
                        errors++;
                        $display("FAIL rand_out d%0d p%0d n%0d O=%h OV=%b want %h %b", d, p, n, act_o[d][p], act_ov[d][p],
                                 eo[d][p], eov[d][p]);
                    end
                end
                checks++;
                if (coll[d] !== ecoll[d] || rdy[d] !== erdy[d]) begin
                    errors++; $display("FAIL rand_ctl d%0d n%0d COLL=%b READY=%b want %b %b", d, n, coll[d], rdy[d], ecoll[d], erdy[d]);
                end
            end
        end
    endtask

    task automatic test_mid_clear_reset();
        test_reset();
        repeat (5) step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d] !== 1'b0) begin errors++; $display("FAIL mid_clear d%0d READY=%b want 0", d, rdy[d]); end
        end
        test_reset();
        test_ready_timing();
        test_read_all();
    endtask

    initial begin
        idle();
        drive();
        @(negedge CE);
        test_reset();
        test_ready_timing();
        test_read_all();
        test_byte_mask();
        test_read_first();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_mid_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
